// File: rtl/reg_file_if.sv
// Register-file port bundle: two read ports, one write port, clear request, ready.
// Master drives addresses/write/clear; slave returns read data and ready.
interface reg_file_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            we;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            clr_req;
  logic            ready;

  modport master (
    output rs1_addr, rs2_addr, we, wr_addr, wr_data, clr_req,
    input  rs1_data, rs2_data, ready
  );

  modport slave (
    input  rs1_addr, rs2_addr, we, wr_addr, wr_data, clr_req,
    output rs1_data, rs2_data, ready
  );
endinterface

// File: rtl/reg_file.sv
// Self-clearing 2R1W register file, x0 hardwired to zero; REG_FILE_BYPASS_EN adds write-to-read forwarding.
// Latency: reads combinational, writes land on the next edge; no backpressure, writes are ignored while ready=0.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic       clk,
  input logic       rst_n,
  reg_file_if.slave bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   idx, idx_nx;
  logic            last, last_nx;
  logic            ready_q, ready_nx;
  logic            clr_we;
  logic            wr_en;
  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      idx     <= AW'(1);
      last    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      last    <= last_nx;
      ready_q <= ready_nx;
    end
  end

  // 'last' marks that the top index has been cleared; the index itself never wraps
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    last_nx  = last;
    ready_nx = ready_q;
    clr_we   = 1'b0;
    case (state)
      INIT: begin
        if (last) begin
          state_nx = RUN;
          ready_nx = 1'b1;
        end else begin
          clr_we = 1'b1;
          if (idx == AW'(NREG - 1)) last_nx = 1'b1;
          else                      idx_nx  = idx + AW'(1);
        end
      end
      RUN: begin
        if (bus.clr_req) begin
          state_nx = INIT;
          idx_nx   = AW'(1);
          last_nx  = 1'b0;
          ready_nx = 1'b0;
        end
      end
      default: state_nx = INIT;
    endcase
  end

  assign wr_en = (state == RUN) && bus.we && (bus.wr_addr != '0);

  // No reset on the array so it can map onto RAM; INIT does the clearing
  always_ff @(posedge clk) begin
    if (clr_we)     regs[idx]         <= '0;
    else if (wr_en) regs[bus.wr_addr] <= bus.wr_data;
  end

  always_comb begin
    bus.rs1_data = '0;
    if (state == RUN && bus.rs1_addr != '0) begin
`ifdef REG_FILE_BYPASS_EN
      if (wr_en && bus.wr_addr == bus.rs1_addr) bus.rs1_data = bus.wr_data;
      else                                      bus.rs1_data = regs[bus.rs1_addr];
`else
      bus.rs1_data = regs[bus.rs1_addr];
`endif
    end
  end

  always_comb begin
    bus.rs2_data = '0;
    if (state == RUN && bus.rs2_addr != '0) begin
`ifdef REG_FILE_BYPASS_EN
      if (wr_en && bus.wr_addr == bus.rs2_addr) bus.rs2_data = bus.wr_data;
      else                                      bus.rs2_data = regs[bus.rs2_addr];
`else
      bus.rs2_data = regs[bus.rs2_addr];
`endif
    end
  end

  assign bus.ready = ready_q;
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: 32x32 main instance plus an 8x16 instance sharing clock and reset.
module tb_reg_file;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_if #(.XLEN(32), .NREG(32)) bus ();
  reg_file_if #(.XLEN(16), .NREG(8))  sbus ();

  reg_file #(.XLEN(32), .NREG(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  reg_file #(.XLEN(16), .NREG(8))  sdut (.clk(clk), .rst_n(rst_n), .bus(sbus));

`ifdef REG_FILE_BYPASS_EN
  localparam logic [31:0] BYPV = 32'hA5A5A5A5;
`else
  localparam logic [31:0] BYPV = 32'h0;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input string nm, input logic [31:0] e);
    sb_t s;
    s.name = nm;
    s.exp  = e;
    sbq.push_back(s);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    sb_t s;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_underflow actual=%h required=<queued value>", act);
    end else begin
      s = sbq.pop_front();
      chk(s.name, act, s.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we      = 1'b0;
    bus.clr_req = 1'b0;
  endtask

  // Expectations go in when the read addresses are driven, compared once outputs settle
  task automatic rd_chk(input string nm, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] e1, input logic [31:0] e2);
    bus.rs1_addr = a1;
    bus.rs2_addr = a2;
    sb_push({nm, "_rs1"}, e1);
    sb_push({nm, "_rs2"}, e2);
    #2;
    sb_pop(bus.rs1_data);
    sb_pop(bus.rs2_data);
  endtask

  task automatic wait_ready(input string nm, input int exp_edges);
    int got;
    got = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus.ready) begin
        got = i;
        break;
      end
    end
    chk(nm, got, exp_edges);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_edge;
    int s_edge;
    int got;

    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd1,  32'h0,        32'h0};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd0,  32'h12345678, 5'd5,  5'd1,  32'hDEADBEEF, 32'h0};
    tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    tbl[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd0,  5'd0,  32'h0,        32'h0};
    tbl[5] = '{1'b1, 5'd1,  32'h00001111, 5'd31, 5'd5,  32'hCAFEF00D, 32'hDEADBEEF};
    tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 32'h00001111, 32'hCAFEF00D};
    tbl[7] = '{1'b1, 5'd5,  32'h0,        5'd1,  5'd1,  32'h00001111, 32'h00001111};
    tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h0,        32'hCAFEF00D};

    idle();
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rs1_addr  = 5'd5;
    bus.rs2_addr  = 5'd31;
    sbus.we       = 1'b0;
    sbus.clr_req  = 1'b0;
    sbus.wr_addr  = '0;
    sbus.wr_data  = '0;
    sbus.rs1_addr = '0;
    sbus.rs2_addr = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", {31'b0, bus.ready}, 32'h0);
    chk("rst_small_ready", {31'b0, sbus.ready}, 32'h0);
    rd_chk("rst_read", 5'd5, 5'd31, 32'h0, 32'h0);

    // Initial clear: main ready on edge 32, small ready on edge 8
    rst_n  = 1'b1;
    b_edge = 0;
    s_edge = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.ready  && b_edge == 0) b_edge = i;
      if (sbus.ready && s_edge == 0) s_edge = i;
    end
    chk("init_ready_edge", b_edge, 32);
    chk("small_init_ready_edge", s_edge, 8);
    for (int a = 0; a < 32; a++) begin
      rd_chk($sformatf("init_zero_%0d", a), 5'(a), 5'(31 - a), 32'h0, 32'h0);
      tick();
    end

    // Small instance: full-width write to the top register
    sbus.we      = 1'b1;
    sbus.wr_addr = 3'd7;
    sbus.wr_data = 16'hFFFF;
    tick();
    sbus.we       = 1'b0;
    sbus.rs1_addr = 3'd7;
    #2;
    chk("small_x7", {16'h0, sbus.rs1_data}, 32'h0000FFFF);

    // Table vectors: one row per cycle
    for (int i = 0; i < 9; i++) begin
      bus.we      = tbl[i].we;
      bus.wr_addr = tbl[i].wa;
      bus.wr_data = tbl[i].wd;
      rd_chk($sformatf("vec%0d", i), tbl[i].r1, tbl[i].r2, tbl[i].e1, tbl[i].e2);
      tick();
    end
    idle();

    // Same-cycle write and read
    bus.we      = 1'b1;
    bus.wr_addr = 5'd7;
    bus.wr_data = 32'hA5A5A5A5;
    rd_chk("byp_same", 5'd7, 5'd7, BYPV, BYPV);
    tick();
    idle();
    rd_chk("byp_next", 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5);
    tick();

    // Fill x1..x31 with their indices
    for (int a = 1; a < 32; a++) begin
      bus.we      = 1'b1;
      bus.wr_addr = 5'(a);
      bus.wr_data = 32'(a);
      tick();
    end
    idle();
    rd_chk("fill", 5'd3, 5'd31, 32'd3, 32'd31);

    // Clear request with a simultaneous write
    bus.we      = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 32'h55;
    bus.clr_req = 1'b1;
    chk("clr_ready_before", {31'b0, bus.ready}, 32'h1);
    tick();
    idle();
    chk("clr_ready_drop", {31'b0, bus.ready}, 32'h0);
    rd_chk("clr_init_read", 5'd3, 5'd31, 32'h0, 32'h0);
    // Second clr_req and a write mid-clear must both be ignored
    got = 0;
    for (int i = 1; i <= 100; i++) begin
      bus.clr_req = (i == 10);
      bus.we      = (i == 20);
      bus.wr_addr = 5'd9;
      bus.wr_data = 32'hFFFFFFFF;
      tick();
      if (bus.ready) begin
        got = i;
        break;
      end
    end
    idle();
    chk("clr_ready_edge", got, 32);
    for (int a = 0; a < 32; a++) begin
      rd_chk($sformatf("post_clr_%0d", a), 5'(a), 5'(31 - a), 32'h0, 32'h0);
      tick();
    end

    // Reset abort in RUN, then again partway through INIT
    bus.we      = 1'b1;
    bus.wr_addr = 5'd12;
    bus.wr_data = 32'h77;
    tick();
    idle();
    rd_chk("pre_rst_x12", 5'd12, 5'd0, 32'h77, 32'h0);
    rst_n = 1'b0;
    tick();
    chk("rst_run_ready", {31'b0, bus.ready}, 32'h0);
    rd_chk("rst_run_read", 5'd12, 5'd12, 32'h0, 32'h0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mid_init_ready", {31'b0, bus.ready}, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_ready("rst_restart_edge", 32);
    rd_chk("rst_x12_cleared", 5'd12, 5'd5, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
